// File: rtl/matmul_microsequencer.sv
// Microcoded fetch/decode/execute sequencer driving lock-stepped matmul cores.
// state   | meaning
// IDLE    | waiting for start, all strobes low
// FETCH1  | instruction read at PC
// FETCH2  | latch instruction, advance PC
// DECODE  | settle decode of IR
// EXEC1   | first execute step of the opcode
// EXEC2   | second memory step (LDAC load / STAC write recovery)
// HALT    | one-cycle done pulse before returning to IDLE
module matmul_microsequencer #(
  parameter int INSTR_W   = 16,
  parameter int NUM_CORES = 4,
  parameter int Z_MODE    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [INSTR_W-1:0]   ir_in,
  input  logic [NUM_CORES-1:0] z,
  output logic [3:0]           reg_select,
  output logic                 mem_select,
  output logic [1:0]           alu_op,
  output logic                 read,
  output logic                 write,
  output logic                 inc_pc,
  output logic                 jump,
  output logic [INSTR_W-9:0]   jump_addr,
  output logic                 ac_write,
  output logic [1:0]           ac_src,
  output logic                 reg_write,
  output logic                 inc_ac,
  output logic                 inc_tp1,
  output logic                 inc_tp2,
  output logic                 reset_ac,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH1 = 3'd1,
    S_FETCH2 = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC1  = 3'd4,
    S_EXEC2  = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_LDAC   = 4'd1;
  localparam logic [3:0] OP_STAC   = 4'd2;
  localparam logic [3:0] OP_MVAC   = 4'd3;
  localparam logic [3:0] OP_MVR    = 4'd4;
  localparam logic [3:0] OP_ADD    = 4'd5;
  localparam logic [3:0] OP_SUB    = 4'd6;
  localparam logic [3:0] OP_MUL    = 4'd7;
  localparam logic [3:0] OP_INCAC  = 4'd8;
  localparam logic [3:0] OP_INCTP1 = 4'd9;
  localparam logic [3:0] OP_INCTP2 = 4'd10;
  localparam logic [3:0] OP_RSTAC  = 4'd11;
  localparam logic [3:0] OP_JPNZ   = 4'd12;
  localparam logic [3:0] OP_ENDOP  = 4'd15;

  state_t               r_state;
  state_t               w_next;
  logic [INSTR_W-1:0]   r_ir;
  logic [3:0]           w_op;
  logic                 w_zred;

  assign w_op   = r_ir[3:0];
  assign w_zred = (Z_MODE == 0) ? (&z) : (|z);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH2) r_ir <= ir_in;
    end
  end

  always_comb begin
    w_next     = r_state;
    reg_select = 4'd0;
    mem_select = 1'b0;
    alu_op     = 2'd0;
    read       = 1'b0;
    write      = 1'b0;
    inc_pc     = 1'b0;
    jump       = 1'b0;
    jump_addr  = '0;
    ac_write   = 1'b0;
    ac_src     = 2'd0;
    reg_write  = 1'b0;
    inc_ac     = 1'b0;
    inc_tp1    = 1'b0;
    inc_tp2    = 1'b0;
    reset_ac   = 1'b0;
    busy       = (r_state != S_IDLE);
    done       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_FETCH1;
      end
      S_FETCH1: begin
        read   = 1'b1;
        w_next = S_FETCH2;
      end
      S_FETCH2: begin
        inc_pc = 1'b1;
        w_next = S_DECODE;
      end
      S_DECODE: begin
        w_next = S_EXEC1;
      end
      S_EXEC1: begin
        w_next = S_FETCH1;
        case (w_op)
          OP_LDAC: begin
            read       = 1'b1;
            mem_select = 1'b1;
            w_next     = S_EXEC2;
          end
          OP_STAC: begin
            write      = 1'b1;
            mem_select = 1'b1;
            w_next     = S_EXEC2;
          end
          OP_MVAC: begin
            reg_select = r_ir[7:4];
            reg_write  = 1'b1;
          end
          OP_MVR: begin
            reg_select = r_ir[7:4];
            ac_write   = 1'b1;
            ac_src     = 2'd1;
          end
          OP_ADD: begin
            ac_write = 1'b1;
            ac_src   = 2'd2;
            alu_op   = 2'd1;
          end
          OP_SUB: begin
            ac_write = 1'b1;
            ac_src   = 2'd2;
            alu_op   = 2'd2;
          end
          OP_MUL: begin
            ac_write = 1'b1;
            ac_src   = 2'd2;
            alu_op   = 2'd3;
          end
          OP_INCAC:  inc_ac   = 1'b1;
          OP_INCTP1: inc_tp1  = 1'b1;
          OP_INCTP2: inc_tp2  = 1'b1;
          OP_RSTAC:  reset_ac = 1'b1;
          OP_JPNZ: begin
            // z is only looked at here; the PC load is taken when the reduction is false
            jump_addr = r_ir[INSTR_W-1:8];
            jump      = ~w_zred;
          end
          OP_ENDOP:  w_next = S_HALT;
          default: ;
        endcase
      end
      S_EXEC2: begin
        if (w_op == OP_LDAC) begin
          ac_write = 1'b1;
          ac_src   = 2'd0;
        end
        w_next = S_FETCH1;
      end
      S_HALT: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_matmul_microsequencer.sv
// Bench for matmul_microsequencer: per-instruction cycle model versus two DUTs (AND and OR zero reduction).
module tb_matmul_microsequencer;

  typedef struct packed {
    logic [3:0] reg_select;
    logic       mem_select;
    logic [1:0] alu_op;
    logic       read;
    logic       write;
    logic       inc_pc;
    logic       jump;
    logic [7:0] jump_addr;
    logic       ac_write;
    logic [1:0] ac_src;
    logic       reg_write;
    logic       inc_ac;
    logic       inc_tp1;
    logic       inc_tp2;
    logic       reset_ac;
    logic       busy;
    logic       done;
  } outs_t;

  typedef struct {
    outs_t       o;
    bit          f2;
    logic [15:0] ir;
    bit          jp;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] ir_in = '0;
  logic [3:0]  z = '0;

  always #5 clk = ~clk;

  logic [3:0] d0_reg_select, d1_reg_select;
  logic       d0_mem_select, d1_mem_select;
  logic [1:0] d0_alu_op, d1_alu_op;
  logic       d0_read, d1_read, d0_write, d1_write, d0_inc_pc, d1_inc_pc;
  logic       d0_jump, d1_jump;
  logic [7:0] d0_jump_addr, d1_jump_addr;
  logic       d0_ac_write, d1_ac_write;
  logic [1:0] d0_ac_src, d1_ac_src;
  logic       d0_reg_write, d1_reg_write;
  logic       d0_inc_ac, d1_inc_ac, d0_inc_tp1, d1_inc_tp1, d0_inc_tp2, d1_inc_tp2;
  logic       d0_reset_ac, d1_reset_ac, d0_busy, d1_busy, d0_done, d1_done;

  matmul_microsequencer #(.INSTR_W(16), .NUM_CORES(4), .Z_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .ir_in(ir_in), .z(z),
    .reg_select(d0_reg_select), .mem_select(d0_mem_select), .alu_op(d0_alu_op),
    .read(d0_read), .write(d0_write), .inc_pc(d0_inc_pc), .jump(d0_jump),
    .jump_addr(d0_jump_addr), .ac_write(d0_ac_write), .ac_src(d0_ac_src),
    .reg_write(d0_reg_write), .inc_ac(d0_inc_ac), .inc_tp1(d0_inc_tp1),
    .inc_tp2(d0_inc_tp2), .reset_ac(d0_reset_ac), .busy(d0_busy), .done(d0_done)
  );

  matmul_microsequencer #(.INSTR_W(16), .NUM_CORES(4), .Z_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .ir_in(ir_in), .z(z),
    .reg_select(d1_reg_select), .mem_select(d1_mem_select), .alu_op(d1_alu_op),
    .read(d1_read), .write(d1_write), .inc_pc(d1_inc_pc), .jump(d1_jump),
    .jump_addr(d1_jump_addr), .ac_write(d1_ac_write), .ac_src(d1_ac_src),
    .reg_write(d1_reg_write), .inc_ac(d1_inc_ac), .inc_tp1(d1_inc_tp1),
    .inc_tp2(d1_inc_tp2), .reset_ac(d1_reset_ac), .busy(d1_busy), .done(d1_done)
  );

  outs_t o0, o1;
  assign o0 = {d0_reg_select, d0_mem_select, d0_alu_op, d0_read, d0_write, d0_inc_pc,
               d0_jump, d0_jump_addr, d0_ac_write, d0_ac_src, d0_reg_write, d0_inc_ac,
               d0_inc_tp1, d0_inc_tp2, d0_reset_ac, d0_busy, d0_done};
  assign o1 = {d1_reg_select, d1_mem_select, d1_alu_op, d1_read, d1_write, d1_inc_pc,
               d1_jump, d1_jump_addr, d1_ac_write, d1_ac_src, d1_reg_write, d1_inc_ac,
               d1_inc_tp1, d1_inc_tp2, d1_reset_ac, d1_busy, d1_done};

  ent_t        sched[$];
  ent_t        exp_cur, exp_next, idle_e;
  logic [15:0] next_prog[$];
  int          n_pass = 0, n_total = 0, cyc = 0;
  bit          chk_en = 0, z_rand = 0;
  logic [3:0]  z_drv = '0;

  int         f1_cyc[$];
  int         wr_cnt, rd_ar_cnt, ldac_cnt, rw_cnt, done_cnt, j0_cnt, j1_cnt, busy_rise;
  logic [3:0] rs_last;
  logic [7:0] ja_last;
  logic       busy_prev = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, req);
  endtask

  task automatic clr_obs();
    f1_cyc.delete();
    wr_cnt = 0; rd_ar_cnt = 0; ldac_cnt = 0; rw_cnt = 0; done_cnt = 0;
    j0_cnt = 0; j1_cnt = 0; busy_rise = -1; rs_last = '0; ja_last = '0;
  endtask

  task automatic push(input outs_t o, input bit f2, input logic [15:0] ir, input bit jp);
    ent_t e;
    e.o = o; e.o.busy = 1'b1; e.f2 = f2; e.ir = ir; e.jp = jp;
    sched.push_back(e);
  endtask

  // One instruction = fetch, fetch/latch, decode, execute (+ a second step for memory ops or HALT).
  task automatic add_instr(input logic [15:0] ins);
    outs_t      o;
    logic [3:0] op;
    op = ins[3:0];
    o = '0; o.read = 1'b1;   push(o, 0, '0, 0);
    o = '0; o.inc_pc = 1'b1; push(o, 1, ins, 0);
    o = '0;                  push(o, 0, '0, 0);
    o = '0;
    case (op)
      4'd1: begin o.read = 1'b1; o.mem_select = 1'b1; end
      4'd2: begin o.write = 1'b1; o.mem_select = 1'b1; end
      4'd3: begin o.reg_write = 1'b1; o.reg_select = ins[7:4]; end
      4'd4: begin o.ac_write = 1'b1; o.ac_src = 2'd1; o.reg_select = ins[7:4]; end
      4'd5, 4'd6, 4'd7: begin o.ac_write = 1'b1; o.ac_src = 2'd2; o.alu_op = 2'(op - 4'd4); end
      4'd8:  o.inc_ac = 1'b1;
      4'd9:  o.inc_tp1 = 1'b1;
      4'd10: o.inc_tp2 = 1'b1;
      4'd11: o.reset_ac = 1'b1;
      4'd12: o.jump_addr = ins[15:8];
      default: ;
    endcase
    push(o, 0, '0, op == 4'd12);
    if (op == 4'd1) begin
      o = '0; o.ac_write = 1'b1; push(o, 0, '0, 0);
    end else if (op == 4'd2) begin
      o = '0; push(o, 0, '0, 0);
    end else if (op == 4'd15) begin
      o = '0; o.done = 1'b1; push(o, 0, '0, 0);
    end
  endtask

  task automatic launch();
    logic [15:0] w;
    if (next_prog.size() == 0) begin
      int n;
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) begin
        w = 16'($urandom);
        w[3:0] = 4'($urandom_range(0, 14));
        add_instr(w);
      end
      w = 16'($urandom);
      w[3:0] = 4'hF;
      add_instr(w);
    end else begin
      foreach (next_prog[i]) add_instr(next_prog[i]);
      next_prog.delete();
    end
  endtask

  // Drive one cycle of inputs at the falling edge and predict the next cycle's outputs.
  task automatic step(input bit st, input bit rs);
    @(negedge clk);
    exp_cur = exp_next;
    start = st;
    reset = rs;
    z = z_rand ? 4'($urandom) : z_drv;
    ir_in = exp_cur.f2 ? exp_cur.ir : 16'($urandom);
    if (rs) begin
      sched.delete();
      exp_next = idle_e;
    end else begin
      if (st && !exp_cur.o.busy) launch();
      if (sched.size() > 0) exp_next = sched.pop_front();
      else exp_next = idle_e;
    end
  endtask

  initial begin
    forever begin
      outs_t e0, e1;
      @(posedge clk);
      cyc++;
      #1;
      if (chk_en) begin
        e0 = exp_next.o;
        e1 = exp_next.o;
        if (exp_next.jp) begin
          e0.jump = ~(&z);
          e1.jump = ~(|z);
        end
        chk("outs_and_mode", 64'(o0), 64'(e0));
        chk("outs_or_mode", 64'(o1), 64'(e1));
        if (o0.read && !o0.mem_select) f1_cyc.push_back(cyc);
        if (o0.read && o0.mem_select) rd_ar_cnt++;
        if (o0.write) wr_cnt++;
        if (o0.ac_write && o0.ac_src == 2'd0) ldac_cnt++;
        if (o0.reg_write) begin rw_cnt++; rs_last = o0.reg_select; end
        if (o0.done) done_cnt++;
        if (o0.jump) begin j0_cnt++; ja_last = o0.jump_addr; end
        if (o1.jump) j1_cnt++;
        if (o0.busy && !busy_prev) busy_rise = cyc;
        busy_prev = o0.busy;
      end
    end
  end

  function automatic int gap(input int a, input int b);
    if (f1_cyc.size() > b) return f1_cyc[b] - f1_cyc[a];
    return -1;
  endfunction

  initial begin
    int s;
    idle_e.o = '0; idle_e.f2 = 0; idle_e.ir = '0; idle_e.jp = 0;
    exp_next = idle_e;
    clr_obs();

    step(0, 1);
    chk_en = 1;
    step(0, 1);
    step(0, 1);
    step(0, 0);
    chk("reset_idle_outputs", 64'(o0), 64'd0);

    // NOP then ENDOP, with a stray start pulse mid-run
    clr_obs();
    next_prog = '{16'h0000, 16'h000F};
    step(1, 0);
    s = cyc;
    for (int i = 1; i <= 14; i++) step(i == 4, 0);
    chk("busy_rise_latency", 64'(busy_rise - s), 64'd1);
    chk("nop_fetch_count", 64'(f1_cyc.size()), 64'd2);
    chk("nop_fetch_gap", 64'(gap(0, 1)), 64'd4);
    chk("endop_done_pulses", 64'(done_cnt), 64'd1);
    chk("busy_low_after_halt", 64'(o0.busy), 64'd0);

    // LDAC, STAC, ENDOP
    clr_obs();
    next_prog = '{16'h0001, 16'h0002, 16'h000F};
    step(1, 0);
    for (int i = 0; i < 20; i++) step(0, 0);
    chk("ldac_len", 64'(gap(0, 1)), 64'd5);
    chk("stac_len", 64'(gap(1, 2)), 64'd5);
    chk("stac_write_pulses", 64'(wr_cnt), 64'd1);
    chk("ldac_ar_reads", 64'(rd_ar_cnt), 64'd1);
    chk("ldac_ac_loads", 64'(ldac_cnt), 64'd1);

    // MVAC r5
    clr_obs();
    next_prog = '{16'h0053, 16'h000F};
    step(1, 0);
    for (int i = 0; i < 12; i++) step(0, 0);
    chk("mvac_reg_select", 64'(rs_last), 64'd5);
    chk("mvac_reg_writes", 64'(rw_cnt), 64'd1);

    // JPNZ 0x2A under several zero-flag patterns
    clr_obs();
    z_drv = 4'b0111;
    next_prog = '{16'h2A0C, 16'h000F};
    step(1, 0);
    for (int i = 0; i < 12; i++) step(0, 0);
    chk("jpnz_and_0111_jump", 64'(j0_cnt), 64'd1);
    chk("jpnz_jump_addr", 64'(ja_last), 64'h2A);
    chk("jpnz_or_0111_jump", 64'(j1_cnt), 64'd0);

    clr_obs();
    z_drv = 4'b1111;
    next_prog = '{16'h2A0C, 16'h000F};
    step(1, 0);
    for (int i = 0; i < 12; i++) step(0, 0);
    chk("jpnz_and_1111_jump", 64'(j0_cnt), 64'd0);

    clr_obs();
    z_drv = 4'b0001;
    next_prog = '{16'h2A0C, 16'h000F};
    step(1, 0);
    for (int i = 0; i < 12; i++) step(0, 0);
    chk("jpnz_or_0001_jump", 64'(j1_cnt), 64'd0);
    chk("jpnz_and_0001_jump", 64'(j0_cnt), 64'd1);

    // Reset on the edge that would enter STAC EXEC1
    clr_obs();
    next_prog = '{16'h0002, 16'h000F};
    step(1, 0);
    step(0, 0);
    step(0, 0);
    step(0, 1);
    step(0, 0);
    chk("reset_mid_stac_idle", 64'(o0), 64'd0);
    for (int i = 0; i < 3; i++) step(0, 0);
    chk("reset_mid_stac_no_write", 64'(wr_cnt), 64'd0);

    // Randomized programs, starts, zero flags and occasional resets
    z_rand = 1;
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 2) == 0, $urandom_range(0, 299) == 0);
    for (int i = 0; i < 30; i++) step(0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
